// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry adder: stage count, saturation limits
// and the segment-size sanity check used at elaboration.
package adder_pkg;

  function automatic int nstages(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic bit seg_fits(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG_W-bit ripple-carry slice; also exposes the carry into its
// top bit so the last slice can derive signed overflow.
module rca_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [SEG_W:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < SEG_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/subtract cut into SEG_W-bit ripple segments with a registered
// carry between them; valid/ready handshake with a single global advance enable.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int               NSTAGES = nstages(WIDTH, SEG_W);
  localparam logic [WIDTH-1:0] SMAX    = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN    = WIDTH'(sat_min(WIDTH));

  if (!seg_fits(WIDTH, SEG_W)) begin : g_bad_seg
    $error("pipelined_carry_adder: WIDTH must be a multiple of SEG_W");
  end

  logic             en;
  logic [WIDTH-1:0] bx;
  logic             c0;

  logic [NSTAGES-1:0]             v_q, c_q;
  logic [NSTAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic                           ovf_q;

  logic [NSTAGES-1:0]             v_in, c_in, seg_co, seg_cm;
  logic [NSTAGES-1:0][WIDTH-1:0]  a_in, b_in, p_in, sum_nx, s_nx;
  logic [NSTAGES-1:0][SEG_W-1:0]  seg_s;
  logic                           ovf_raw;
  logic [WIDTH-1:0]               s_final;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Subtraction is A + ~B + 1, with Cin turned into a borrow.
  assign bx = B ^ {WIDTH{Sub}};
  assign c0 = Cin ^ Sub;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_in[k] = A;
      assign b_in[k] = bx;
      assign c_in[k] = c0;
      assign p_in[k] = '0;
      assign v_in[k] = in_valid;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign p_in[k] = s_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    rca_segment #(.SEG_W(SEG_W)) u_seg (
      .a       (a_in[k][k*SEG_W +: SEG_W]),
      .b       (b_in[k][k*SEG_W +: SEG_W]),
      .ci      (c_in[k]),
      .s       (seg_s[k]),
      .co      (seg_co[k]),
      .c_msb_in(seg_cm[k])
    );
  end

  // Each stage merges its fresh segment into the deskewed partial sum.
  always_comb begin
    for (int i = 0; i < NSTAGES; i++) begin
      sum_nx[i]                    = p_in[i];
      sum_nx[i][i*SEG_W +: SEG_W]  = seg_s[i];
    end
  end

  assign ovf_raw = seg_cm[NSTAGES-1] ^ seg_co[NSTAGES-1];

  always_comb begin
    s_final = sum_nx[NSTAGES-1];
    if ((SAT != 0) && ovf_raw) begin
      s_final = a_in[NSTAGES-1][WIDTH-1] ? SMIN : SMAX;
    end
    s_nx              = sum_nx;
    s_nx[NSTAGES-1]   = s_final;
  end

  // The whole pipe advances together; a stalled output freezes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q   <= v_in;
      c_q   <= seg_co;
      s_q   <= s_nx;
      a_q   <= a_in;
      b_q   <= b_in;
      ovf_q <= ovf_raw;
    end
  end

  assign out_valid = v_q[NSTAGES-1];
  assign S         = s_q[NSTAGES-1];
  assign Cout      = c_q[NSTAGES-1];
  assign Ovf       = ovf_q;

  logic unused_tail;
  assign unused_tail = ^{a_q[NSTAGES-1], b_q[NSTAGES-1], seg_cm};

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined successor to the 8-bit ripple-carry adder used by the filter datapath. It splits a WIDTH-bit add/subtract into SEG_W-bit ripple segments and registers the carry between segments, so the carry chain is cut for timing. It adds a valid/ready handshake with backpressure, a subtract mode, signed-overflow detection and optional signed saturation. It sits between the pixel-product stage and the accumulator of the Laplace filter.

## Interface
- WIDTH, 8: operand/result width in bits.
- SEG_W, 4: bits per pipeline segment; WIDTH % SEG_W == 0 is required (elaboration error otherwise).
- SAT, 0: 1 = clamp S to the signed max/min on signed overflow; 0 = wrap.
- NSTAGES, derived = WIDTH/SEG_W: number of pipeline stages; also the latency in cycles.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set is present.
- in_ready  out  1  block accepts the operand set this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in; acts as a borrow when Sub=1.
- Sub  in  1  0 = A+B+Cin; 1 = A−B−Cin.
- out_valid  out  1  result is present.
- out_ready  in  1  consumer takes the result this cycle.
- S  out  WIDTH  sum or difference, saturated when SAT=1.
- Cout  out  1  raw carry-out of the MSB; never saturated.
- Ovf  out  1  signed overflow of the unsaturated result.

## Operation
- **Operand conditioning at accept:**
  - Bx = B ^ {WIDTH{Sub}}.
  - c0 = Cin ^ Sub.
  - Results: Sub=1, Cin=0 gives A−B; Sub=1, Cin=1 gives A−B−1.
- **Stage k (0..NSTAGES−1):**
  - Adds segment k of A and Bx with the carry registered by stage k−1 (c0 for k=0).
  - Registers the SEG_W-bit partial sum and the carry-out.
  - Operand segments above k travel in skew registers alongside.
  - Partial sums below k travel in deskew registers alongside.
- **Final stage:**
  - Cout = carry out of the MSB.
  - Ovf = carry into MSB ^ carry out of MSB.
  - If SAT=1 and Ovf: S = A[MSB] ? signed min (100..0) : signed max (011..1). Otherwise S = raw sum.
  - Saturation is computed before the output register.
- **Handshake:**
  - Each stage has a valid bit.
  - Global advance en = out_ready | ~out_valid.
  - in_ready = en.
  - A transfer occurs when in_valid & in_ready.
  - When en=0, every stage register and valid bit holds.
  - Bubbles are not collapsed; results emerge in acceptance order.
- **Reset:**
  - rst=1 clears all valid bits, S, Cout and Ovf to 0 on the next edge.
  - in_ready reads 1 during and after reset.
  - rst dominates in_valid; in-flight operations are discarded without any output.

## Timing
- Latency: an operand set accepted at edge t has its result on S/Cout/Ovf with out_valid=1 after edge t+NSTAGES−1.
  - SEG_W=WIDTH gives 1 cycle.
  - 8/4 gives 2 cycles.
- Throughput: 1 result per cycle while out_ready=1.
- out_valid, S, Cout and Ovf are registered outputs.
- in_ready is combinational from out_ready and out_valid (one gate).
- Stall:
  - out_valid=1 & out_ready=0 freezes the pipeline.
  - S, Cout and Ovf stay stable until taken.
  - Inputs presented during a stall are not accepted.
- Simultaneous take and accept (out_ready=1, in_valid=1): the pipeline shifts by one, with no gap.
- Wrap: SAT=0 gives a modulo-2^WIDTH result; Cout carries the unsigned overflow.
- Outputs hold their last value when out_valid=0; consumers ignore them.

## Structure
- Shared package adder_pkg:
  - Function nstages(WIDTH, SEG_W).
  - Functions sat_max(WIDTH) and sat_min(WIDTH).
  - Localparam check for WIDTH % SEG_W.
- Sub-module rca_segment:
  - Combinational SEG_W-bit ripple-carry adder.
  - Ports: a, b, ci, s, co, and c_msb_in, which is used for Ovf in the top segment.
  - Instantiated NSTAGES times via generate.
- Top level holds the skew/deskew registers, valid chain, saturation mux and handshake.

## Test plan
- WIDTH=8, SEG_W=4: A=0xFF, B=0x01, Cin=0, Sub=0 -> two cycles later S=0x00, Cout=1, Ovf=0, out_valid=1.
- Subtract: A=0x05, B=0x07, Sub=1, Cin=0 -> S=0xFE, Cout=0, Ovf=0. Same with Cin=1 -> S=0xFD.
- SAT=1 positive overflow: A=0x7F, B=0x01 -> S=0x7F, Ovf=1, Cout=0.
- SAT=1 negative overflow: A=0x80, B=0xFF -> S=0x80, Ovf=1, Cout=1.
- Backpressure: stream 4 operand sets back-to-back and drop out_ready for 3 cycles starting at cycle 3 -> in_ready=0 during the stall, S held stable, all 4 results delivered in order with none lost or duplicated.
- Exhaustive: all 256×256 A/B pairs with Cin=0 and Cin=1, out_ready toggled randomly -> every {Cout,S} equals A+B+Cin. Repeat for SEG_W ∈ {1, 2, 8} and WIDTH=16 with random operands.
- Reset mid-operation: rst asserted for one cycle with 2 operations in flight -> next cycle out_valid=0, S=0, Cout=0, Ovf=0; no stale result appears after release; the first new operation completes with normal latency.
